memwb_stage: RTL and testbench

MEMWB_STAGE -- requirements
Module: memwb_stage

---
 rtl/memwb_pkg.sv | 29 ++
 rtl/memwb_stage_wb_mux.sv | 27 ++
 rtl/memwb_stage.sv | 142 ++++++++++++++
 tb/tb_memwb_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared types and defaults for the MEM/WB pipeline register slice.
package memwb_pkg;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned RADDR_W_DEF  = 5;
  localparam int unsigned WAIT_MAX_DEF = 255;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    WB_PC4 = 2'd0,
    WB_MEM = 2'd1,
    WB_ALU = 2'd2
  } wb_sel_e;

  // Link address wins over load data, which wins over the ALU result.
  function automatic wb_sel_e wb_select(input logic pc_to_reg, input logic mem_to_reg);
    if (pc_to_reg) begin
      return WB_PC4;
    end else if (mem_to_reg) begin
      return WB_MEM;
    end
    return WB_ALU;
  endfunction

endpackage

// File: rtl/memwb_stage_wb_mux.sv
// Writeback value selection from the held MEM/WB fields.
module wb_mux
  import memwb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              pc_to_reg,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] wb_data
);

  wb_sel_e sel;

  always_comb begin
    sel     = wb_select(pc_to_reg, mem_to_reg);
    wb_data = alu_res;
    case (sel)
      WB_PC4:  wb_data = pc + DATA_W'(4);
      WB_MEM:  wb_data = mem_data;
      default: wb_data = alu_res;
    endcase
  end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline register with load-data wait, flush and sticky load timeout.
module memwb_stage
  import memwb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RADDR_W  = RADDR_W_DEF,
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_pc,
  input  logic [DATA_W-1:0]  in_ir,
  input  logic [DATA_W-1:0]  in_alu_res,
  input  logic [RADDR_W-1:0] in_write_addr,
  input  logic               in_mem_to_reg,
  input  logic               in_pc_to_reg,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_hazard,
  input  logic               flush,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_pc,
  output logic [DATA_W-1:0]  out_ir,
  output logic [DATA_W-1:0]  out_alu_res,
  output logic [DATA_W-1:0]  out_mem_data,
  output logic [RADDR_W-1:0] out_write_addr,
  output logic               out_mem_to_reg,
  output logic               out_pc_to_reg,
  output logic               out_hazard,
  output logic               out_reg_write,
  output logic [DATA_W-1:0]  wb_data,
  output logic               stall_req,
  output logic               err_timeout
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_d;
  logic             err_d;
  logic             reg_write_q;
  logic             cap_fields;
  logic             cap_mem;
  logic             accept;

  assign in_ready      = (state_q == ST_RUN);
  assign stall_req     = ~in_ready;
  assign accept        = in_valid & in_ready;
  assign out_reg_write = reg_write_q & out_valid;

  // Next state, valid, wait counter and capture enables; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_timeout;
    valid_d    = 1'b0;
    cap_fields = 1'b0;
    cap_mem    = 1'b0;
    if (flush) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (accept) begin
        cap_fields = 1'b1;
        if (!in_mem_read) begin
          valid_d = 1'b1;
        end else if (mem_rvalid) begin
          valid_d = 1'b1;
          cap_mem = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
    end else begin
      if (mem_rvalid) begin
        valid_d = 1'b1;
        cap_mem = 1'b1;
        state_d = ST_RUN;
      end else begin
        if (cnt_q != CNT_W'(WAIT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(WAIT_MAX)) begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      err_timeout    <= 1'b0;
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_ir         <= '0;
      out_alu_res    <= '0;
      out_mem_data   <= '0;
      out_write_addr <= '0;
      out_mem_to_reg <= 1'b0;
      out_pc_to_reg  <= 1'b0;
      out_hazard     <= 1'b0;
      reg_write_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_timeout <= err_d;
      out_valid   <= valid_d;
      if (cap_fields) begin
        out_pc         <= in_pc;
        out_ir         <= in_ir;
        out_alu_res    <= in_alu_res;
        out_write_addr <= in_write_addr;
        out_mem_to_reg <= in_mem_to_reg;
        out_pc_to_reg  <= in_pc_to_reg;
        out_hazard     <= in_hazard;
        reg_write_q    <= in_reg_write;
      end
      if (cap_mem) begin
        out_mem_data <= mem_rdata;
      end
    end
  end

  wb_mux #(
    .DATA_W(DATA_W)
  ) u_wb_mux (
    .pc_to_reg (out_pc_to_reg),
    .mem_to_reg(out_mem_to_reg),
    .pc        (out_pc),
    .mem_data  (out_mem_data),
    .alu_res   (out_alu_res),
    .wb_data   (wb_data)
  );

endmodule

// File: tb/tb_memwb_stage.sv
// Self-checking bench for memwb_stage: directed scenarios plus random traffic against a transaction model.
module tb_memwb_stage;

  localparam int WMAX = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc, in_ir, in_alu_res;
  logic [4:0]  in_write_addr;
  logic        in_mem_to_reg, in_pc_to_reg, in_reg_write, in_mem_read, in_hazard;
  logic        flush, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_pc, out_ir, out_alu_res, out_mem_data;
  logic [4:0]  out_write_addr;
  logic        out_mem_to_reg, out_pc_to_reg, out_hazard, out_reg_write;
  logic [31:0] wb_data;
  logic        stall_req, err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model: what the stage is holding and whether a load is outstanding.
  logic [31:0] m_pc, m_ir, m_alu, m_mem;
  logic [4:0]  m_wa;
  logic        m_m2r, m_p2r, m_rw, m_hz, m_valid, m_pend, m_err;
  int          m_waited;

  memwb_stage #(.DATA_W(32), .RADDR_W(5), .WAIT_MAX(WMAX)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_ir(in_ir), .in_alu_res(in_alu_res), .in_write_addr(in_write_addr),
    .in_mem_to_reg(in_mem_to_reg), .in_pc_to_reg(in_pc_to_reg), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_hazard(in_hazard), .flush(flush),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_pc(out_pc), .out_ir(out_ir), .out_alu_res(out_alu_res), .out_mem_data(out_mem_data),
    .out_write_addr(out_write_addr), .out_mem_to_reg(out_mem_to_reg),
    .out_pc_to_reg(out_pc_to_reg), .out_hazard(out_hazard), .out_reg_write(out_reg_write),
    .wb_data(wb_data), .stall_req(stall_req), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_wb();
    if (m_p2r) return m_pc + 32'd4;
    if (m_m2r) return m_mem;
    return m_alu;
  endfunction

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic tick();
    if (!reset) begin
      {m_pc, m_ir, m_alu, m_mem} = '0;
      m_wa = '0; {m_m2r, m_p2r, m_rw, m_hz, m_valid, m_pend, m_err} = '0;
      m_waited = 0;
    end else if (flush) begin
      m_valid = 1'b0; m_pend = 1'b0;
    end else if (!m_pend) begin
      m_valid = 1'b0;
      if (in_valid) begin
        m_pc = in_pc; m_ir = in_ir; m_alu = in_alu_res; m_wa = in_write_addr;
        m_m2r = in_mem_to_reg; m_p2r = in_pc_to_reg; m_rw = in_reg_write; m_hz = in_hazard;
        if (!in_mem_read) m_valid = 1'b1;
        else if (mem_rvalid) begin m_mem = mem_rdata; m_valid = 1'b1; end
        else begin m_pend = 1'b1; m_waited = 0; end
      end
    end else if (mem_rvalid) begin
      m_mem = mem_rdata; m_valid = 1'b1; m_pend = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (m_waited < WMAX) m_waited++;
      if (m_waited == WMAX) m_err = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_ir = '0; in_alu_res = '0; in_write_addr = '0;
    in_mem_to_reg = 1'b0; in_pc_to_reg = 1'b0; in_reg_write = 1'b0; in_mem_read = 1'b0;
    in_hazard = 1'b0; flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    n_cmp++; if ({out_valid, in_ready, stall_req, err_timeout, out_reg_write} !== 5'b01000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 01000", {out_valid, in_ready, stall_req, err_timeout, out_reg_write}); end
    n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL reset_wb: got %h expected 0", wb_data); end
    n_cmp++; if ({out_pc, out_ir, out_alu_res, out_mem_data} !== 128'h0) begin
      n_err++; $display("FAIL reset_fields: got %h expected 0", {out_pc, out_ir, out_alu_res, out_mem_data}); end
  endtask

  task automatic test_alu_op();
    idle_inputs();
    in_valid = 1'b1; in_alu_res = 32'h0000_0010; in_reg_write = 1'b1; in_write_addr = 5'd7;
    tick();
    n_cmp++; if ({out_valid, out_reg_write} !== 2'b11) begin
      n_err++; $display("FAIL alu_valid: got %b expected 11", {out_valid, out_reg_write}); end
    n_cmp++; if (wb_data !== 32'h10) begin n_err++; $display("FAIL alu_wb: got %h expected 00000010", wb_data); end
    in_valid = 1'b0; in_alu_res = 32'h1234_5678;
    tick();
    n_cmp++; if ({out_valid, out_reg_write} !== 2'b00) begin
      n_err++; $display("FAIL bubble_valid: got %b expected 00", {out_valid, out_reg_write}); end
    n_cmp++; if (out_alu_res !== 32'h10 || out_write_addr !== 5'd7) begin
      n_err++; $display("FAIL bubble_hold: got %h/%0d expected 00000010/7", out_alu_res, out_write_addr); end
  endtask

  task automatic test_load_wait();
    idle_inputs();
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_to_reg = 1'b1; in_reg_write = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({stall_req, in_ready, out_valid} !== 3'b100) begin
        n_err++; $display("FAIL load_stall%0d: got %b expected 100", i, {stall_req, in_ready, out_valid}); end
      if (i < 2) tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if ({out_valid, in_ready, out_reg_write} !== 3'b111) begin
      n_err++; $display("FAIL load_done: got %b expected 111", {out_valid, in_ready, out_reg_write}); end
    n_cmp++; if (wb_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_wb: got %h expected deadbeef", wb_data); end
  endtask

  task automatic test_jal_wrap();
    idle_inputs();
    in_valid = 1'b1; in_pc_to_reg = 1'b1; in_mem_to_reg = 1'b1; in_pc = 32'hFFFF_FFFC;
    tick();
    n_cmp++; if (wb_data !== 32'h0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL jal_wrap: got %h/%b expected 00000000/1", wb_data, out_valid); end
  endtask

  task automatic test_flush_wait();
    idle_inputs();
    in_valid = 1'b1; in_mem_read = 1'b1; in_mem_to_reg = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    flush = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL flush_ctrl: got %b expected 01", {out_valid, in_ready}); end
    n_cmp++; if (out_mem_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL flush_mem: got %h expected deadbeef", out_mem_data); end
    mem_rdata = 32'hCAFE_0000;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if (out_mem_data !== 32'hDEAD_BEEF || out_valid !== 1'b0) begin
      n_err++; $display("FAIL stray_rvalid: got %h/%b expected deadbeef/0", out_mem_data, out_valid); end
  endtask

  task automatic test_timeout();
    idle_inputs();
    in_valid = 1'b1; in_mem_read = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= WMAX + 2; i++) begin
      tick();
      n_cmp++; if (err_timeout !== (i >= WMAX) || stall_req !== 1'b1) begin
        n_err++; $display("FAIL timeout_c%0d: got %b/%b expected %b/1", i, err_timeout, stall_req, i >= WMAX); end
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_rvalid = 1'b0;
    n_cmp++; if ({out_valid, err_timeout, in_ready} !== 3'b111 || out_mem_data !== 32'h0BAD_F00D) begin
      n_err++; $display("FAIL timeout_sticky: got %b/%h expected 111/0badf00d", {out_valid, err_timeout, in_ready}, out_mem_data); end
  endtask

  task automatic test_reset_in_wait();
    idle_inputs();
    in_valid = 1'b1; in_mem_read = 1'b1; in_pc = 32'h40; in_alu_res = 32'h99;
    tick();
    in_valid = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    n_cmp++; if ({out_valid, in_ready, stall_req, err_timeout, out_reg_write} !== 5'b01000) begin
      n_err++; $display("FAIL rst_wait_ctrl: got %b expected 01000", {out_valid, in_ready, stall_req, err_timeout, out_reg_write}); end
    n_cmp++; if ({out_pc, out_alu_res, out_mem_data, wb_data} !== 128'h0) begin
      n_err++; $display("FAIL rst_wait_data: got %h expected 0", {out_pc, out_alu_res, out_mem_data, wb_data}); end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      in_ir = $urandom; in_alu_res = $urandom; in_write_addr = 5'($urandom);
      in_mem_to_reg = $urandom_range(0, 1) == 1; in_pc_to_reg = $urandom_range(0, 3) == 0;
      in_reg_write = $urandom_range(0, 1) == 1; in_mem_read = $urandom_range(0, 4) < 2;
      in_hazard = $urandom_range(0, 1) == 1; flush = $urandom_range(0, 9) == 0;
      mem_rvalid = $urandom_range(0, 9) < 3; mem_rdata = $urandom;
      tick();
      n_cmp++; if ({out_valid, in_ready, stall_req, out_reg_write, err_timeout} !==
                   {m_valid, !m_pend, m_pend, m_rw & m_valid, m_err}) begin
        n_err++; $display("FAIL rnd_ctrl@%0d: got %b expected %b", i, {out_valid, in_ready, stall_req, out_reg_write, err_timeout},
                          {m_valid, !m_pend, m_pend, m_rw & m_valid, m_err}); end
      n_cmp++; if (wb_data !== exp_wb() || out_mem_data !== m_mem) begin
        n_err++; $display("FAIL rnd_wb@%0d: got %h/%h expected %h/%h", i, wb_data, out_mem_data, exp_wb(), m_mem); end
      n_cmp++; if ({out_pc, out_ir, out_alu_res, out_write_addr, out_mem_to_reg, out_pc_to_reg, out_hazard} !==
                   {m_pc, m_ir, m_alu, m_wa, m_m2r, m_p2r, m_hz}) begin
        n_err++; $display("FAIL rnd_fields@%0d: got %h expected %h", i,
                          {out_pc, out_ir, out_alu_res, out_write_addr, out_mem_to_reg, out_pc_to_reg, out_hazard},
                          {m_pc, m_ir, m_alu, m_wa, m_m2r, m_p2r, m_hz}); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_wait();
    test_jal_wrap();
    test_flush_wait();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
